// File: rtl/vid_timing_counter.sv
// One axis of a video raster timer: 0..total counter with load, cascade carry and
// NWIN registered compare windows. Define VID_TIMING_MATCH_EN to add the match_val pulse.
module vid_timing_counter #(
   parameter int WID  = 12,
   parameter int NWIN = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                ld,
   input  logic [WID-1:0]      d,
   input  logic [WID-1:0]      total,
   input  logic [NWIN*WID-1:0] win_start,
   input  logic [NWIN*WID-1:0] win_end,
   input  logic [NWIN-1:0]     win_pol,
`ifdef VID_TIMING_MATCH_EN
   input  logic [WID-1:0]      match_val,
`endif
   output logic [WID-1:0]      q,
   output logic                tc,
   output logic                co,
   output logic [NWIN-1:0]     win_o,
   output logic                match_o
);

   logic [WID-1:0]  q_q, q_d;
   logic [NWIN-1:0] win_q, win_d;
   logic            upd;

   assign upd = ld | ce;
   assign tc  = (q_q >= total);
   assign co  = ce & tc;
   assign q   = q_q;
   assign win_o = win_q;

   always_comb begin
      q_d = q_q;
      if (ld)
         q_d = d;
      else if (ce && tc)
         q_d = '0;
      else if (ce)
         q_d = q_q + WID'(1);
   end

   // Windows are evaluated on the next count so win_o lines up with q.
   for (genvar i = 0; i < NWIN; i++) begin : g_win
      logic [WID-1:0] s, e;
      logic           act;
      assign s   = win_start[i*WID +: WID];
      assign e   = win_end[i*WID +: WID];
      assign act = (s < e) ? ((q_d >= s) && (q_d < e)) :
                   (s > e) ? ((q_d >= s) || (q_d < e)) : 1'b0;
      assign win_d[i] = act ^ win_pol[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= '0;
         win_q <= win_pol;
      end else begin
         q_q <= q_d;
         if (upd)
            win_q <= win_d;
      end
   end

`ifdef VID_TIMING_MATCH_EN
   logic match_q;
   always_ff @(posedge clk) begin
      if (rst)
         match_q <= 1'b0;
      else
         match_q <= upd && (q_d == match_val) && (q_d != q_q);
   end
   assign match_o = match_q;
`else
   assign match_o = 1'b0;
`endif

endmodule

// File: tb/tb_vid_timing_counter.sv
// Directed bench for vid_timing_counter: horizontal instance cascaded into a vertical one.
module tb_vid_timing_counter;
   localparam int WID  = 12;
   localparam int NWIN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, ce_h, ld_h;
   logic [WID-1:0]      d_h, total_h, total_v, q_h, q_v, mv_h, mv_v;
   logic [NWIN*WID-1:0] ws_h, we_h, ws_v, we_v;
   logic [NWIN-1:0]     pol_h, pol_v, win_h, win_v;
   logic                tc_h, co_h, tc_v, co_v, match_h, match_v;

   vid_timing_counter #(.WID(WID), .NWIN(NWIN)) u_h (
      .clk(clk), .rst(rst), .ce(ce_h), .ld(ld_h), .d(d_h), .total(total_h),
      .win_start(ws_h), .win_end(we_h), .win_pol(pol_h),
`ifdef VID_TIMING_MATCH_EN
      .match_val(mv_h),
`endif
      .q(q_h), .tc(tc_h), .co(co_h), .win_o(win_h), .match_o(match_h));

   vid_timing_counter #(.WID(WID), .NWIN(NWIN)) u_v (
      .clk(clk), .rst(rst), .ce(co_h), .ld(1'b0), .d(12'd0), .total(total_v),
      .win_start(ws_v), .win_end(we_v), .win_pol(pol_v),
`ifdef VID_TIMING_MATCH_EN
      .match_val(mv_v),
`endif
      .q(q_v), .tc(tc_v), .co(co_v), .win_o(win_v), .match_o(match_v));

   typedef struct {
      logic           ce, ld;
      logic [WID-1:0] d, total, q;
      logic           tc, co;
      logic [1:0]     win;
   } vec_t;
   vec_t vecs[11];

   int n_cmp = 0, n_err = 0;
   int eq, prev, co_cnt, m_cnt, hq, vq, old_h;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_match(input int p, input int c, input int mv);
`ifdef VID_TIMING_MATCH_EN
      return (c == mv) && (c != p);
`else
      return 1'b0;
`endif
   endfunction

   // Free-running horizontal counter with total=799, checked cycle by cycle.
   task automatic run_main(input int n);
      logic w0, w1;
      for (int i = 0; i < n; i++) begin
         prev = eq;
         step();
         eq = (eq >= 799) ? 0 : eq + 1;
         w0 = !(eq >= 656 && eq <= 751);
         w1 = (eq >= 790 || eq <= 9);
         chk("main_q", 32'(q_h), 32'(eq));
         chk("main_tc", 32'(tc_h), 32'(eq == 799));
         chk("main_win", 32'(win_h), 32'({w1, w0}));
         chk("main_match", 32'(match_h), 32'(exp_match(prev, eq, 5)));
         if (co_h) co_cnt++;
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 12'd500, 12'd799, 12'd500, 1'b0, 1'b0, 2'b01};
      vecs[1]  = '{1'b0, 1'b0, 12'd0,   12'd300, 12'd500, 1'b1, 1'b0, 2'b01};
      vecs[2]  = '{1'b1, 1'b0, 12'd0,   12'd300, 12'd0,   1'b0, 1'b0, 2'b11};
      vecs[3]  = '{1'b1, 1'b1, 12'd900, 12'd799, 12'd900, 1'b1, 1'b1, 2'b11};
      vecs[4]  = '{1'b1, 1'b0, 12'd0,   12'd799, 12'd0,   1'b0, 1'b0, 2'b11};
      vecs[5]  = '{1'b1, 1'b0, 12'd0,   12'd799, 12'd1,   1'b0, 1'b0, 2'b11};
      vecs[6]  = '{1'b0, 1'b1, 12'd655, 12'd799, 12'd655, 1'b0, 1'b0, 2'b01};
      vecs[7]  = '{1'b1, 1'b0, 12'd0,   12'd799, 12'd656, 1'b0, 1'b0, 2'b00};
      vecs[8]  = '{1'b0, 1'b0, 12'd0,   12'd799, 12'd656, 1'b0, 1'b0, 2'b00};
      vecs[9]  = '{1'b0, 1'b1, 12'd0,   12'd0,   12'd0,   1'b1, 1'b0, 2'b11};
      vecs[10] = '{1'b1, 1'b0, 12'd0,   12'd0,   12'd0,   1'b1, 1'b1, 2'b11};

      rst = 1'b1; ce_h = 1'b0; ld_h = 1'b0; d_h = '0; total_h = 12'd799;
      ws_h = {12'd790, 12'd656}; we_h = {12'd10, 12'd752}; pol_h = 2'b01;
      total_v = 12'd2; ws_v = {12'd7, 12'd1}; we_v = {12'd7, 12'd2}; pol_v = 2'b10;
      mv_h = 12'd5; mv_v = 12'd0;
      step(); step();
      chk("rst_q", 32'(q_h), 32'd0);
      chk("rst_win", 32'(win_h), 32'b01);
      chk("rst_tc", 32'(tc_h), 32'd0);
      chk("rst_match", 32'(match_h), 32'd0);
      chk("rst_win_v", 32'(win_v), 32'b10);

      rst = 1'b0; ce_h = 1'b1; eq = 0; co_cnt = 0;
      run_main(1600);
      chk("co_pulses", 32'(co_cnt), 32'd2);
      run_main(798);

      foreach (vecs[k]) begin
         ce_h = vecs[k].ce; ld_h = vecs[k].ld; d_h = vecs[k].d; total_h = vecs[k].total;
         step();
         chk($sformatf("vec%0d_q", k), 32'(q_h), 32'(vecs[k].q));
         chk($sformatf("vec%0d_tc", k), 32'(tc_h), 32'(vecs[k].tc));
         chk($sformatf("vec%0d_co", k), 32'(co_h), 32'(vecs[k].co));
         chk($sformatf("vec%0d_win", k), 32'(win_h), 32'(vecs[k].win));
      end
      ld_h = 1'b0;

      // Cascade: h total=3 carries into v total=2; mid-frame reset at i==13.
      rst = 1'b1; total_h = 12'd3; ce_h = 1'b1;
      step();
      rst = 1'b0; hq = 0; vq = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 13) begin
            rst = 1'b1;
            step();
            chk("mid_rst_qh", 32'(q_h), 32'd0);
            chk("mid_rst_qv", 32'(q_v), 32'd0);
            chk("mid_rst_win_h", 32'(win_h), 32'b01);
            chk("mid_rst_win_v", 32'(win_v), 32'b10);
            rst = 1'b0; hq = 0; vq = 0;
         end else begin
            step();
            old_h = hq;
            hq = (hq >= 3) ? 0 : hq + 1;
            if (old_h >= 3) vq = (vq >= 2) ? 0 : vq + 1;
            chk("casc_qh", 32'(q_h), 32'(hq));
            chk("casc_qv", 32'(q_v), 32'(vq));
            chk("casc_win_v", 32'(win_v), 32'({1'b1, vq == 1}));
         end
      end

      // Raster-line match pulse; always zero without the optional feature.
      rst = 1'b1; total_h = 12'd9; mv_h = 12'd5; ce_h = 1'b1;
      step();
      rst = 1'b0; eq = 0; m_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         prev = eq;
         step();
         eq = (eq >= 9) ? 0 : eq + 1;
         chk("m_q", 32'(q_h), 32'(eq));
         chk("m_pulse", 32'(match_h), 32'(exp_match(prev, eq, 5)));
         if (match_h) m_cnt++;
      end
`ifdef VID_TIMING_MATCH_EN
      chk("m_count", 32'(m_cnt), 32'd3);
`else
      chk("m_count", 32'(m_cnt), 32'd0);
`endif
      ce_h = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("m_hold_q", 32'(q_h), 32'd5);
         chk("m_hold", 32'(match_h), 32'd0);
      end
      ld_h = 1'b1; d_h = 12'd5;
      step();
      chk("m_ld_same", 32'(match_h), 32'd0);
      ld_h = 1'b0;
      step();
      chk("m_ld_after", 32'(match_h), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
